// File: rtl/decimal_input_unit_pkg.sv
// Shared definitions for the decimal keypad entry path: key codes,
// entry FSM states and default range limits.
package decimal_input_unit_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned MAG_W   = 10;
  localparam int unsigned VALUE_W = 8;

  localparam int unsigned DEF_MAX_DIGITS = 3;
  localparam int unsigned DEF_POS_LIMIT  = 127;
  localparam int unsigned DEF_NEG_LIMIT  = 128;

  localparam logic [3:0] KEY_SIGN  = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;
  localparam logic [3:0] KEY_BKSP  = 4'hD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } entry_state_e;

endpackage

// File: rtl/bcd3_to_binary.sv
// Combinational 3-digit BCD to unsigned binary magnitude (0..999).
module bcd3_to_binary
  import decimal_input_unit_pkg::*;
(
  input  logic [DIGIT_W-1:0] hund,
  input  logic [DIGIT_W-1:0] tens,
  input  logic [DIGIT_W-1:0] ones,
  output logic [MAG_W-1:0]   mag_c
);

  // Weighted sum of the three digits.
  always_comb begin
    mag_c = MAG_W'(hund) * MAG_W'(100) + MAG_W'(tens) * MAG_W'(10) + MAG_W'(ones);
  end

endmodule

// File: rtl/decimal_input_unit.sv
// Keypad decimal entry: builds a signed 3-digit BCD entry from key events
// and converts it to an 8-bit two's-complement operand on ENTER.
// Optional backspace key enabled by defining DECIMAL_INPUT_BACKSPACE_EN.
module decimal_input_unit
  import decimal_input_unit_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = DEF_MAX_DIGITS,
  parameter int unsigned POS_LIMIT  = DEF_POS_LIMIT,
  parameter int unsigned NEG_LIMIT  = DEF_NEG_LIMIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [3:0]         key_code,
  output logic [VALUE_W-1:0] value,
  output logic               value_valid,
  output logic               err,
  output logic               neg,
  output logic [DIGIT_W-1:0] ones,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] hund,
  output logic [1:0]         ndigits
);

  entry_state_e       state, state_d;
  logic [VALUE_W-1:0] value_d;
  logic               value_valid_d, err_d, neg_d;
  logic [DIGIT_W-1:0] ones_d, tens_d, hund_d;
  logic [1:0]         ndigits_d;
  logic [MAG_W-1:0]   mag_c;
  logic               in_range_c;

  bcd3_to_binary u_bcd3_to_binary (
    .hund  (hund),
    .tens  (tens),
    .ones  (ones),
    .mag_c (mag_c)
  );

  // Range check of the current entry against the signed limits.
  always_comb begin
    in_range_c = neg ? (32'(mag_c) <= NEG_LIMIT) : (32'(mag_c) <= POS_LIMIT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      value       <= '0;
      value_valid <= 1'b0;
      err         <= 1'b0;
      neg         <= 1'b0;
      ones        <= '0;
      tens        <= '0;
      hund        <= '0;
      ndigits     <= '0;
    end else begin
      state       <= state_d;
      value       <= value_d;
      value_valid <= value_valid_d;
      err         <= err_d;
      neg         <= neg_d;
      ones        <= ones_d;
      tens        <= tens_d;
      hund        <= hund_d;
      ndigits     <= ndigits_d;
    end
  end

  // Key decode: next state and next register values.
  always_comb begin
    state_d       = state;
    value_d       = value;
    value_valid_d = 1'b0;
    err_d         = err;
    neg_d         = neg;
    ones_d        = ones;
    tens_d        = tens;
    hund_d        = hund;
    ndigits_d     = ndigits;

    if (key_valid) begin
      if (key_code <= 4'd9) begin
        if (state == ENTRY) begin
          if (32'(ndigits) < MAX_DIGITS) begin
            hund_d    = tens;
            tens_d    = ones;
            ones_d    = key_code;
            ndigits_d = ndigits + 2'd1;
          end
        end else begin
          // A sign chosen in IDLE before the first digit is kept.
          hund_d    = '0;
          tens_d    = '0;
          ones_d    = key_code;
          ndigits_d = 2'd1;
          err_d     = 1'b0;
          if (state != IDLE) neg_d = 1'b0;
          state_d   = ENTRY;
        end
      end else begin
        case (key_code)
          KEY_SIGN: begin
            if (state == IDLE || state == ENTRY) begin
              neg_d = ~neg;
            end else begin
              hund_d    = '0;
              tens_d    = '0;
              ones_d    = '0;
              ndigits_d = '0;
              neg_d     = 1'b1;
              err_d     = 1'b0;
              state_d   = IDLE;
            end
          end
          KEY_CLEAR: begin
            hund_d    = '0;
            tens_d    = '0;
            ones_d    = '0;
            ndigits_d = '0;
            neg_d     = 1'b0;
            err_d     = 1'b0;
            state_d   = IDLE;
          end
          KEY_ENTER: begin
            if (state == IDLE || state == ENTRY) begin
              if (in_range_c) begin
                value_d       = neg ? VALUE_W'(~mag_c[7:0] + 8'd1) : mag_c[7:0];
                value_valid_d = 1'b1;
                state_d       = DONE;
              end else begin
                err_d   = 1'b1;
                state_d = ERROR;
              end
            end
          end
`ifdef DECIMAL_INPUT_BACKSPACE_EN
          KEY_BKSP: begin
            if (state == ENTRY) begin
              ones_d    = tens;
              tens_d    = hund;
              hund_d    = '0;
              ndigits_d = ndigits - 2'd1;
              if (ndigits == 2'd1) state_d = IDLE;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decimal_input_unit.sv
// Directed self-checking bench for decimal_input_unit.
module tb_decimal_input_unit;
  import decimal_input_unit_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] value;
  logic       value_valid, err, neg;
  logic [3:0] ones, tens, hund;
  logic [1:0] ndigits;

  int checks = 0;
  int errors = 0;

  decimal_input_unit dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .value       (value),
    .value_valid (value_valid),
    .err         (err),
    .neg         (neg),
    .ones        (ones),
    .tens        (tens),
    .hund        (hund),
    .ndigits     (ndigits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One key strobe; returns at the falling edge after it was sampled.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'hF;
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_neg"},  8'(neg), 8'h00);
    check({tag, "_ones"}, 8'(ones), 8'h00);
    check({tag, "_tens"}, 8'(tens), 8'h00);
    check({tag, "_hund"}, 8'(hund), 8'h00);
    check({tag, "_nd"},   8'(ndigits), 8'h00);
    check({tag, "_err"},  8'(err), 8'h00);
  endtask

  logic [7:0] bksp_exp;

  initial begin
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_value", value, 8'h00);
    check("rst_vv", 8'(value_valid), 8'h00);
    check_clear("rst");

    // +127
    press(4'd1); press(4'd2); press(4'd7);
    check("127_ones", 8'(ones), 8'h07);
    check("127_tens", 8'(tens), 8'h02);
    check("127_hund", 8'(hund), 8'h01);
    check("127_nd", 8'(ndigits), 8'h03);
    press(KEY_ENTER);
    check("127_value", value, 8'h7F);
    check("127_vv", 8'(value_valid), 8'h01);
    check("127_err", 8'(err), 8'h00);
    @(negedge clk);
    check("127_vv_drop", 8'(value_valid), 8'h00);
    check("127_hold", value, 8'h7F);

    // Sign from DONE starts a negative entry; -128
    press(KEY_SIGN);
    check("sgn_neg", 8'(neg), 8'h01);
    check("sgn_nd", 8'(ndigits), 8'h00);
    press(4'd1); press(4'd2); press(4'd8);
    check("m128_neg", 8'(neg), 8'h01);
    press(KEY_ENTER);
    check("m128_value", value, 8'h80);
    check("m128_vv", 8'(value_valid), 8'h01);

    // +128 out of range
    press(4'd1); press(4'd2); press(4'd8);
    check("p128_neg", 8'(neg), 8'h00);
    press(KEY_ENTER);
    check("p128_err", 8'(err), 8'h01);
    check("p128_vv", 8'(value_valid), 8'h00);
    check("p128_value", value, 8'h80);
    press(KEY_ENTER);
    check("err_enter_vv", 8'(value_valid), 8'h00);
    check("err_enter_err", 8'(err), 8'h01);

    // -5
    press(4'd5);
    check("m5_err_clr", 8'(err), 8'h00);
    press(KEY_SIGN);
    press(KEY_ENTER);
    check("m5_value", value, 8'hFB);
    check("m5_vv", 8'(value_valid), 8'h01);

    // -0 gives 0x00
    press(KEY_SIGN); press(4'd0);
    check("m0_neg", 8'(neg), 8'h01);
    press(KEY_ENTER);
    check("m0_value", value, 8'h00);
    check("m0_vv", 8'(value_valid), 8'h01);

    // +64 then overflow digits, ignored keys, clear
    press(4'd6); press(4'd4); press(KEY_ENTER);
    check("64_value", value, 8'h40);
    press(4'd9); press(4'd9); press(4'd9); press(4'd4);
    check("999_ones", 8'(ones), 8'h09);
    check("999_tens", 8'(tens), 8'h09);
    check("999_hund", 8'(hund), 8'h09);
    check("999_nd", 8'(ndigits), 8'h03);
    press(4'hE);
    check("keyE_nd", 8'(ndigits), 8'h03);
    @(negedge clk);
    key_code = 4'd5;
    @(negedge clk);
    check("novalid_ones", 8'(ones), 8'h09);
    press(KEY_CLEAR);
    check_clear("clr");
    check("clr_value", value, 8'h40);

    // Enter with no digits yields 0
    press(KEY_ENTER);
    check("empty_value", value, 8'h00);
    check("empty_vv", 8'(value_valid), 8'h01);

    // Backspace key
`ifdef DECIMAL_INPUT_BACKSPACE_EN
    bksp_exp = 8'h0C;
`else
    bksp_exp = 8'h7B;
`endif
    press(4'd1); press(4'd2); press(4'd3); press(KEY_BKSP); press(KEY_ENTER);
    check("bksp_value", value, bksp_exp);
    check("bksp_vv", 8'(value_valid), 8'h01);

    // Reset overrides a simultaneous ENTER
    press(4'd4); press(4'd2);
    @(negedge clk);
    reset     = 1'b1;
    key_valid = 1'b1;
    key_code  = KEY_ENTER;
    @(negedge clk);
    reset     = 1'b0;
    key_valid = 1'b0;
    check("rst2_vv", 8'(value_valid), 8'h00);
    check("rst2_value", value, 8'h00);
    check_clear("rst2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
